// File: rtl/mem_noc_arbiter.sv
// Round-robin arbiter sharing one single-beat memory port among N_MST requesters.
// The grant order is kept in an ID FIFO so that in-order responses return to their owners.
package mem_noc_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;

endpackage

module mem_noc_arbiter
    import mem_noc_pkg::*;
#(
    parameter int unsigned N_MST           = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_MST-1:0]                    s_req_valid,
    output logic [N_MST-1:0]                    s_req_ready,
    input  mem_req_t [N_MST-1:0]                s_req,
    output logic [N_MST-1:0]                    s_resp_valid,
    input  logic [N_MST-1:0]                    s_resp_ready,
    output mem_resp_t [N_MST-1:0]               s_resp,
    output logic                                m_req_valid,
    input  logic                                m_req_ready,
    output mem_req_t                            m_req,
    input  logic                                m_resp_valid,
    output logic                                m_resp_ready,
    input  mem_resp_t                           m_resp,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
    output logic                                err_unexp_resp
);

    localparam int unsigned IDW = $clog2(N_MST);
    localparam int unsigned AW  = $clog2(MAX_OUTSTANDING);
    localparam int unsigned PW  = AW + 1;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] winner;
    logic           found;
    logic           slot_free;
    logic           can_grant;
    logic           grant;

    logic [IDW-1:0] id_mem [MAX_OUTSTANDING];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           empty;
    logic [IDW-1:0] head;
    logic           pop;

    assign slot_free = ~m_req_valid | m_req_ready;
    assign can_grant = slot_free & (outstanding < PW'(MAX_OUTSTANDING));
    assign grant     = can_grant & found;

    // First valid requester after rr_ptr, wrapping modulo N_MST.
    always_comb begin
        int unsigned cand;
        cand   = 0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 1; k <= N_MST; k++) begin
            cand = (32'(rr_ptr) + k) % N_MST;
            if (!found && s_req_valid[IDW'(cand)]) begin
                found  = 1'b1;
                winner = IDW'(cand);
            end
        end
    end

    always_comb begin
        s_req_ready = '0;
        for (int unsigned i = 0; i < N_MST; i++) begin
            s_req_ready[i] = grant & (winner == IDW'(i));
        end
    end

    // Output slot holds its payload until the downstream handshake completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_req_valid <= 1'b0;
            m_req       <= '0;
            rr_ptr      <= IDW'(N_MST - 1);
        end else if (grant) begin
            m_req_valid <= 1'b1;
            m_req       <= s_req[winner];
            rr_ptr      <= winner;
        end else if (m_req_ready) begin
            m_req_valid <= 1'b0;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign head  = id_mem[rd_ptr[AW-1:0]];

    always_comb begin
        s_resp_valid = '0;
        for (int unsigned i = 0; i < N_MST; i++) begin
            s_resp_valid[i] = m_resp_valid & ~empty & (head == IDW'(i));
            s_resp[i]       = m_resp;
        end
    end

    // With no owner recorded the response is swallowed and flagged.
    assign m_resp_ready = empty ? 1'b1 : s_resp_ready[head];
    assign pop          = m_resp_valid & m_resp_ready & ~empty;

    always_ff @(posedge clk) begin
        if (grant) begin
            id_mem[wr_ptr[AW-1:0]] <= winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            outstanding    <= '0;
            err_unexp_resp <= 1'b0;
        end else begin
            if (grant) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({grant, pop})
                2'b10:   outstanding <= outstanding + PW'(1);
                2'b01:   outstanding <= outstanding - PW'(1);
                default: outstanding <= outstanding;
            endcase
            err_unexp_resp <= m_resp_valid & empty;
        end
    end

endmodule

// File: tb/tb_mem_noc_arbiter.sv
// Randomized bench for mem_noc_arbiter against a queue-based transaction model.
module tb_mem_noc_arbiter;
    import mem_noc_pkg::*;

    localparam int unsigned N    = 2;
    localparam int unsigned MAXO = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          s_req_valid;
    logic [N-1:0]          s_req_ready;
    mem_req_t [N-1:0]      s_req;
    logic [N-1:0]          s_resp_valid;
    logic [N-1:0]          s_resp_ready;
    mem_resp_t [N-1:0]     s_resp;
    logic                  m_req_valid;
    logic                  m_req_ready;
    mem_req_t              m_req;
    logic                  m_resp_valid;
    logic                  m_resp_ready;
    mem_resp_t             m_resp;
    logic [$clog2(MAXO):0] outstanding;
    logic                  err_unexp_resp;

    mem_noc_arbiter #(.N_MST(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_req_valid    (s_req_valid),
        .s_req_ready    (s_req_ready),
        .s_req          (s_req),
        .s_resp_valid   (s_resp_valid),
        .s_resp_ready   (s_resp_ready),
        .s_resp         (s_resp),
        .m_req_valid    (m_req_valid),
        .m_req_ready    (m_req_ready),
        .m_req          (m_req),
        .m_resp_valid   (m_resp_valid),
        .m_resp_ready   (m_resp_ready),
        .m_resp         (m_resp),
        .outstanding    (outstanding),
        .err_unexp_resp (err_unexp_resp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: owner queue, last winner, and the pending downstream request.
    int       owners[$];
    int       last_win;
    bit       slot_valid;
    mem_req_t slot_req;
    bit       err_flag;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        owners.delete();
        last_win   = N - 1;
        slot_valid = 1'b0;
        err_flag   = 1'b0;
    endtask

    task automatic step(input int p_req, input int p_mrr, input int p_mresp,
                        input int p_srr, input int p_rst);
        int            n;
        int            win;
        int            hd;
        bit            can;
        bit            mrr_exp;
        bit            do_pop;
        logic [N-1:0]  rdy_exp;
        logic [N-1:0]  rv_exp;
        @(negedge clk);
        rst          = ($urandom_range(99) < p_rst);
        m_req_ready  = ($urandom_range(99) < p_mrr);
        m_resp_valid = ($urandom_range(99) < p_mresp);
        m_resp.rdata = $urandom;
        m_resp.err   = 1'($urandom);
        for (int i = 0; i < N; i++) begin
            s_req_valid[i]  = ($urandom_range(99) < p_req);
            s_resp_ready[i] = ($urandom_range(99) < p_srr);
            s_req[i].addr   = $urandom;
            s_req[i].wdata  = $urandom;
            s_req[i].be     = 4'($urandom);
            s_req[i].we     = 1'($urandom);
        end
        #1;
        if (rst) begin
            @(posedge clk);
            model_reset();
            return;
        end
        n   = owners.size();
        can = (!slot_valid || m_req_ready) && (n < MAXO);
        win = -1;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last_win + k) % N;
            if (win < 0 && s_req_valid[j]) win = j;
        end
        rdy_exp = '0;
        if (can && win >= 0) rdy_exp[win] = 1'b1;
        hd      = (n > 0) ? owners[0] : -1;
        rv_exp  = '0;
        if (m_resp_valid && n > 0) rv_exp[hd] = 1'b1;
        mrr_exp = (n == 0) ? 1'b1 : s_resp_ready[hd];

        check("s_req_ready", 128'(s_req_ready), 128'(rdy_exp));
        check("m_req_valid", 128'(m_req_valid), 128'(slot_valid));
        if (slot_valid) check("m_req", 128'(m_req), 128'(slot_req));
        check("outstanding", 128'(outstanding), 128'(n));
        check("s_resp_valid", 128'(s_resp_valid), 128'(rv_exp));
        check("m_resp_ready", 128'(m_resp_ready), 128'(mrr_exp));
        check("err_unexp_resp", 128'(err_unexp_resp), 128'(err_flag));
        if (rv_exp != 0) check("s_resp", 128'(s_resp[hd]), 128'(m_resp));

        do_pop = m_resp_valid && mrr_exp && (n > 0);
        @(posedge clk);
        err_flag = m_resp_valid && (n == 0);
        if (do_pop) void'(owners.pop_front());
        if (can && win >= 0) begin
            owners.push_back(win);
            slot_valid = 1'b1;
            slot_req   = s_req[win];
            last_win   = win;
        end else if (m_req_ready) begin
            slot_valid = 1'b0;
        end
    endtask

    task automatic run(input int cycles, input int p_req, input int p_mrr,
                       input int p_mresp, input int p_srr, input int p_rst);
        for (int c = 0; c < cycles; c++) step(p_req, p_mrr, p_mresp, p_srr, p_rst);
    endtask

    initial begin
        rst          = 1'b1;
        s_req_valid  = '0;
        s_resp_ready = '0;
        s_req        = '0;
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b0;
        m_resp       = '0;
        model_reset();
        repeat (2) @(posedge clk);
        run(3, 0, 100, 0, 100, 0);       // idle after reset
        run(200, 95, 100, 50, 80, 0);    // contention at full throughput
        run(100, 80, 15, 40, 70, 0);     // downstream backpressure
        run(60, 90, 100, 0, 100, 0);     // fill ID FIFO, no responses
        run(20, 0, 100, 70, 30, 0);      // drain with response stalls
        run(20, 0, 100, 60, 100, 0);     // unexpected responses
        run(600, 60, 60, 50, 60, 3);     // mixed traffic with resets
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
